// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared constants, state encoding and command record for the DMA command queue
package dma_pkg;

    // Largest transfer the downstream controller accepts, in bytes.
    localparam int unsigned MAX_LEN = 28;

    // Low address/length bits that must be zero for word alignment.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } dma_state_e;

    // Command record at the default 32-bit address / 5-bit length widths.
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [4:0]  len;
    } dma_cmd_t;

    function automatic logic word_aligned(input logic [1:0] lsbs);
        return (lsbs & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// rtl/dma_cmd_fifo.sv - synchronous circular command FIFO with occupancy level and flush
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   push, push_data   write request; ignored when full or during flush
//   pop               read request; ignored when empty or during flush
//   flush             empties the FIFO next cycle (beats push and pop)
//   head_data         oldest entry (valid when !empty)
//   full, empty       occupancy flags
//   level             number of stored entries
module dma_cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 69
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    // DEPTH is a power of two, so pointer increment wraps DEPTH-1 -> 0 naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level gates every read of it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dma_cmd_queue.sv
// rtl/dma_cmd_queue.sv - validating descriptor queue that launches commands into dma_controller
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready        host command handshake (ready = queue not full)
//   cmd_src/cmd_dst/cmd_len    command operands
//   flush                      drop all queued (not in-flight) commands
//   trigger                    1-cycle launch pulse
//   source_address, destination_add, length
//                              operands, updated only when a launch starts
//   done                       controller completion (level or pulse; rising edge used)
//   busy                       transfer launching or in flight
//   level                      queued entry count
//   err_cmd                    1-cycle pulse after an illegal command is accepted
//   err_timeout                1-cycle pulse after a transfer is abandoned
//   done_count                 completed transfers, wraps at 2^16
module dma_cmd_queue #(
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 5,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_W-1:0]        cmd_src,
    input  logic [ADDR_W-1:0]        cmd_dst,
    input  logic [LEN_W-1:0]         cmd_len,
    input  logic                     flush,
    output logic                     trigger,
    output logic [ADDR_W-1:0]        source_address,
    output logic [ADDR_W-1:0]        destination_add,
    output logic [LEN_W-1:0]         length,
    input  logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_cmd,
    output logic                     err_timeout,
    output logic [15:0]              done_count
);

    import dma_pkg::*;

    localparam int CMD_W = 2 * ADDR_W + LEN_W;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_LAUNCH = LAUNCH;
    localparam logic [1:0] S_WAIT   = WAIT_DONE;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] head;
    logic             cmd_fire;
    logic             cmd_legal;
    logic             push;
    logic             pop;
    logic             done_rise;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [15:0]       done_count_q, done_count_d;
    logic              trigger_q, trigger_d;
    logic              busy_q, busy_d;
    logic              err_cmd_q, err_cmd_d;
    logic              err_timeout_q, err_timeout_d;
    logic              done_q;

    assign cmd_ready = ~fifo_full;
    assign cmd_fire  = cmd_valid & cmd_ready;

    assign cmd_legal = (cmd_len != '0)
                     && word_aligned(cmd_len[1:0])
                     && (32'(cmd_len) <= MAX_LEN)
                     && word_aligned(cmd_src[1:0])
                     && word_aligned(cmd_dst[1:0]);

    // Illegal commands still complete the handshake; they are just never stored.
    assign push = cmd_fire & cmd_legal;

    // Flush wins over pop so a command being discarded is never launched.
    assign pop = (state_q == S_IDLE) & ~fifo_empty & ~flush;

    assign done_rise = done & ~done_q;

    dma_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({cmd_src, cmd_dst, cmd_len}),
        .pop       (pop),
        .flush     (flush),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        len_d         = len_q;
        timer_d       = timer_q;
        done_count_d  = done_count_q;
        trigger_d     = 1'b0;
        err_timeout_d = 1'b0;
        err_cmd_d     = cmd_fire & ~cmd_legal;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    src_d     = head[CMD_W-1 -: ADDR_W];
                    dst_d     = head[LEN_W +: ADDR_W];
                    len_d     = head[LEN_W-1:0];
                    trigger_d = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // A done edge seen here belongs to no launch of ours; done_q still absorbs it.
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    done_count_d = done_count_q + 16'd1;
                    state_d      = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            timer_q       <= '0;
            done_count_q  <= '0;
            trigger_q     <= 1'b0;
            busy_q        <= 1'b0;
            err_cmd_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            len_q         <= len_d;
            timer_q       <= timer_d;
            done_count_q  <= done_count_d;
            trigger_q     <= trigger_d;
            busy_q        <= busy_d;
            err_cmd_q     <= err_cmd_d;
            err_timeout_q <= err_timeout_d;
            done_q        <= done;
        end
    end

    assign trigger         = trigger_q;
    assign busy            = busy_q;
    assign source_address  = src_q;
    assign destination_add = dst_q;
    assign length          = len_q;
    assign err_cmd         = err_cmd_q;
    assign err_timeout     = err_timeout_q;
    assign done_count      = done_count_q;

endmodule

// File: tb/tb_dma_cmd_queue.sv
// tb/tb_dma_cmd_queue.sv - self-checking bench for dma_cmd_queue
module tb_dma_cmd_queue;

    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_src = '0;
    logic [31:0] cmd_dst = '0;
    logic [4:0]  cmd_len = '0;
    logic        flush = 1'b0;
    logic        trigger;
    logic [31:0] source_address;
    logic [31:0] destination_add;
    logic [4:0]  length;
    logic        done = 1'b0;
    logic        busy;
    logic [2:0]  level;
    logic        err_cmd;
    logic        err_timeout;
    logic [15:0] done_count;

    int       total = 0;
    int       bad = 0;
    int       err_seen = 0;
    int       exp_done = 0;
    bit       auto_done = 1'b0;
    dma_cmd_t exp_q[$];
    dma_cmd_t last_cmd = '0;
    dma_cmd_t mon_e;

    dma_cmd_queue #(
        .DEPTH       (4),
        .ADDR_W      (32),
        .LEN_W       (5),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_src         (cmd_src),
        .cmd_dst         (cmd_dst),
        .cmd_len         (cmd_len),
        .flush           (flush),
        .trigger         (trigger),
        .source_address  (source_address),
        .destination_add (destination_add),
        .length          (length),
        .done            (done),
        .busy            (busy),
        .level           (level),
        .err_cmd         (err_cmd),
        .err_timeout     (err_timeout),
        .done_count      (done_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit spec_legal(input logic [31:0] s, input logic [31:0] d, input logic [4:0] l);
        return (l != 0) && (l % 4 == 0) && (l <= 28) && (s % 4 == 0) && (d % 4 == 0);
    endfunction

    task automatic push_cmd(input logic [31:0] s, input logic [31:0] d, input logic [4:0] l);
        int n;
        n = 0;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            chk("push_ready_timeout", cmd_ready, 1'b1);
        end else begin
            if (spec_legal(s, d, l)) exp_q.push_back('{src: s, dst: d, len: l});
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || level != 0) && n < 600) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, {busy, level}, 4'd0);
        tick();
        tick();
    endtask

    // Launch scoreboard: each trigger must carry the oldest legal command still
    // expected, and operands must hold for the whole transfer.
    always @(negedge clk) begin
        if (!reset) begin
            if (err_cmd) err_seen++;
            if (trigger) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_trigger", trigger, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("launch_src", source_address, mon_e.src);
                    chk("launch_dst", destination_add, mon_e.dst);
                    chk("launch_len", length, mon_e.len);
                    last_cmd = mon_e;
                end
            end else if (busy) begin
                chk("hold_src", source_address, last_cmd.src);
                chk("hold_dst", destination_add, last_cmd.dst);
                chk("hold_len", length, last_cmd.len);
            end
        end
    end

    // Controller stand-in: answers each transfer in WAIT_DONE after a short random delay.
    initial begin
        int d;
        forever begin
            @(posedge clk);
            #2;
            if (auto_done && busy && !trigger) begin
                d = $urandom_range(0, 4);
                for (int k = 0; k < d; k++) begin
                    @(posedge clk);
                    #2;
                end
                done = 1'b1;
                @(posedge clk);
                #2;
                done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int base_err;
        int n_ill;
        int n_leg;
        logic [31:0] rs;
        logic [31:0] rd;
        logic [4:0]  rl;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_trigger", trigger, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_err_cmd", err_cmd, 1'b0);
        chk("rst_err_to", err_timeout, 1'b0);
        chk("rst_done_count", done_count, 16'd0);
        chk("rst_operands", {source_address, destination_add, length}, 69'd0);

        // 1: single command, trigger at N+2 for one cycle, done counted
        push_cmd(32'h1000, 32'h2000, 5'd4);
        chk("t1_trig_n1", trigger, 1'b0);
        chk("t1_level", level, 3'd1);
        tick();
        chk("t1_trig_n2", trigger, 1'b1);
        chk("t1_src", source_address, 32'h1000);
        chk("t1_dst", destination_add, 32'h2000);
        chk("t1_len", length, 5'd4);
        tick();
        chk("t1_trig_pulse", trigger, 1'b0);
        chk("t1_busy", busy, 1'b1);
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        exp_done = 1;
        chk("t1_done_count", done_count, 16'd1);
        chk("t1_idle", busy, 1'b0);
        tick();
        chk("t1_src_kept", source_address, 32'h1000);

        // 2: illegal commands rejected
        push_cmd(32'h1000, 32'h2000, 5'd6);
        chk("t2_err_len", err_cmd, 1'b1);
        chk("t2_level_a", level, 3'd0);
        tick();
        chk("t2_err_clear", err_cmd, 1'b0);
        push_cmd(32'h1002, 32'h2000, 5'd8);
        chk("t2_err_src", err_cmd, 1'b1);
        repeat (3) tick();
        chk("t2_no_launch", {trigger, busy, level}, 5'd0);

        // 3: stall done, fill the queue, back-pressure, then drain in order
        for (int i = 0; i < 5; i++) begin
            push_cmd(32'h3000 + 32'(i * 64), 32'h4000 + 32'(i * 64), 5'(4 * (i + 1)));
        end
        chk("t3_level_full", level, 3'd4);
        chk("t3_ready_low", cmd_ready, 1'b0);
        chk("t3_busy", busy, 1'b1);
        cmd_src   = 32'h3F00;
        cmd_dst   = 32'h4F00;
        cmd_len   = 5'd4;
        cmd_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("t3_held_off", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        chk("t3_level_hold", level, 3'd4);
        auto_done = 1'b1;
        wait_idle("t3");
        auto_done = 1'b0;
        exp_done += 5;
        chk("t3_done_count", done_count, 16'(exp_done));
        chk("t3_queue_empty", exp_q.size(), 0);

        // 4: back-to-back commands, next trigger two cycles after each done rise
        push_cmd(32'h1200, 32'h2200, 5'd8);
        push_cmd(32'h1300, 32'h2300, 5'd16);
        push_cmd(32'h1100, 32'h2100, 5'd28);
        for (int k = 0; k < 3; k++) begin
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("t4_trig_m1", trigger, 1'b0);
            tick();
            chk("t4_trig_m2", trigger, (k < 2) ? 1'b1 : 1'b0);
        end
        exp_done += 3;
        chk("t4_done_count", done_count, 16'(exp_done));

        // 5: timeout after 16 cycles in WAIT_DONE, then next command launches
        push_cmd(32'h5000, 32'h6000, 5'd12);
        push_cmd(32'h5100, 32'h6100, 5'd16);
        chk("t5_trig", trigger, 1'b1);
        repeat (16) tick();
        chk("t5_before_to", {busy, err_timeout}, 2'b10);
        tick();
        chk("t5_err_to", err_timeout, 1'b1);
        chk("t5_idle", busy, 1'b0);
        tick();
        chk("t5_err_to_pulse", err_timeout, 1'b0);
        chk("t5_next_trig", trigger, 1'b1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        exp_done += 1;
        chk("t5_done_count", done_count, 16'(exp_done));

        // 6a: reset in the middle of a transfer with two queued
        push_cmd(32'h7000, 32'h8000, 5'd4);
        push_cmd(32'h7100, 32'h8100, 5'd8);
        push_cmd(32'h7200, 32'h8200, 5'd12);
        chk("t6_level2", level, 3'd2);
        tick();
        chk("t6_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_done = 0;
        chk("t6_rst_level", level, 3'd0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_trig", trigger, 1'b0);
        chk("t6_rst_done_count", done_count, 16'd0);
        repeat (4) tick();
        chk("t6_rst_quiet", {trigger, busy, level}, 5'd0);

        // 6b: flush with three queued, in-flight transfer still completes
        push_cmd(32'h9000, 32'hA000, 5'd4);
        push_cmd(32'h9100, 32'hA100, 5'd8);
        push_cmd(32'h9200, 32'hA200, 5'd12);
        push_cmd(32'h9300, 32'hA300, 5'd16);
        chk("t6_level3", level, 3'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        chk("t6_flush_level", level, 3'd0);
        chk("t6_flush_busy", busy, 1'b1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        exp_done += 1;
        chk("t6_flush_done", done_count, 16'(exp_done));
        repeat (3) tick();
        chk("t6_after_flush", {trigger, busy}, 2'b00);

        // Push in the same cycle as flush is dropped
        cmd_src   = 32'hB000;
        cmd_dst   = 32'hC000;
        cmd_len   = 5'd8;
        cmd_valid = 1'b1;
        flush     = 1'b1;
        tick();
        cmd_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_push_level", level, 3'd0);
        repeat (3) tick();
        chk("flush_push_idle", busy, 1'b0);

        // Randomized traffic against the scoreboard
        base_err  = err_seen;
        n_ill     = 0;
        n_leg     = 0;
        auto_done = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rs = $urandom & 32'hFFFF_FFFC;
            rd = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rs[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) rd[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) rl = 5'(4 * $urandom_range(1, 7));
            else rl = 5'($urandom_range(0, 31));
            if (spec_legal(rs, rd, rl)) n_leg++;
            else n_ill++;
            push_cmd(rs, rd, rl);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle("rnd");
        auto_done = 1'b0;
        chk("rnd_err_cmds", err_seen - base_err, n_ill);
        chk("rnd_done_count", done_count, 16'(exp_done + n_leg));
        chk("rnd_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
